fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001: The module SHALL have parameter DEPTH, default FETCHQ_DEPTH (4), giving the number of queue entries; it must be a power of two and at least 2.
REQ-002: The module SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003: The module SHALL have port nRST, input, 1 bit: reset, asynchronous and active-high (1 = reset asserted).
REQ-004: The module SHALL have port push, input, 1 bit: fetch stage offers an instruction; driven by fetch ihit qualified by no stall.
REQ-005: The module SHALL have port instr_in, input, word_t: fetched instruction word (imemload).
REQ-006: The module SHALL have port npc_in, input, word_t: PC+4 associated with instr_in.
REQ-007: The module SHALL have port pop, input, 1 bit: decode consumes the head entry, i.e. decode is not stalled by the hazard unit.
REQ-008: The module SHALL have port flush, input, 1 bit: branch or jump resolved taken; discard all queued instructions.
REQ-009: The module SHALL have port instr_out, output, word_t: head instruction to decode.
REQ-010: The module SHALL have port npc_out, output, word_t: head PC+4 to decode.
REQ-011: The module SHALL have port valid_out, output, 1 bit: the head entry is valid.
REQ-012: The module SHALL have port full, output, 1 bit: the queue holds DEPTH entries; fetch stage uses it as a stall.
REQ-013: The module SHALL have port empty, output, 1 bit: the queue holds 0 entries.
REQ-014: The module SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy, 0..DEPTH.

Function
REQ-015: The queue SHALL be first-word fall-through: instr_out and npc_out are driven combinationally from the head entry with zero-cycle latency once the entry is written.
REQ-016: When empty, the outputs SHALL be valid_out=0, instr_out=32'h0 (NOP) and npc_out=32'h0, never stale data.
REQ-017: An accepted push SHALL write {instr_in, npc_in} at the tail, advance the tail pointer modulo DEPTH and increment count.
REQ-018: An accepted pop SHALL advance the head pointer modulo DEPTH and decrement count.
REQ-019: A push SHALL be accepted only if !full, or if full and an accepted pop occurs in the same cycle; otherwise it is dropped with no state change.
REQ-020: A pop while empty SHALL be ignored; a simultaneous push while empty SHALL be accepted, with the entry visible on the next cycle.
REQ-021: An accepted push and accepted pop in the same cycle SHALL leave count unchanged and advance both pointers.
REQ-022: flush SHALL have the highest priority: the next edge sets head=tail=0 and count=0, and push/pop in the same cycle are discarded.
REQ-023: full SHALL equal (count==DEPTH) and empty SHALL equal (count==0), both derived from registered count with no combinational path from push or pop.
REQ-024: Occupancy state SHALL be EMPTY, PARTIAL or FULL, decoded from count; transitions follow REQ-017 to REQ-022, with pointer wrap-around from DEPTH-1 to 0 for both head and tail.

Reset
REQ-025: Asserting nRST SHALL immediately clear head, tail and count to 0, with outputs per REQ-016, full=0, empty=1 and count=0.
REQ-026: Storage contents SHALL not need reset; valid_out must never expose unreset storage.
REQ-027: Reset asserted mid-operation SHALL discard all entries, and the first push after deassertion SHALL be written at entry 0.

Structure
REQ-028: FETCHQ_DEPTH SHALL be added to cpu_types_pkg, with word_t reused from the package.
REQ-029: A new interface fetch_queue_if.vh SHALL carry the non-clock ports, with modports for the fetch side, the decode side and the tb.
REQ-030: The module SHALL have no sub-module; storage arrays, pointers and the counter are inline, with separate always_ff (async reset) and always_comb blocks.

Verification
REQ-031: The bench SHALL cover reset then 4 pushes (instr 0x11..0x44, npc 0x4..0x10) with pop=0 -> count=4, full=1, instr_out=0x11.
REQ-032: The bench SHALL cover a full queue with push=1 (0x55) and pop=0 -> 0x55 dropped, count stays 4; then pop 4 times -> outputs 0x11, 0x22, 0x33, 0x44, then empty=1 and instr_out=0.
REQ-033: The bench SHALL cover a full queue with push=1 (0x55) and pop=1 -> count=4, head=0x22, and 0x55 later emerges after 0x44, proving tail wrap.
REQ-034: The bench SHALL cover 3 entries queued with flush=1, push=1 and pop=1 in one cycle -> next cycle count=0, empty=1, valid_out=0, and the pushed word is discarded.
REQ-035: The bench SHALL cover an empty queue with push=1 (0xAA) and pop=1 -> pop ignored; next cycle count=1 and instr_out=0xAA.
REQ-036: The bench SHALL cover 2 entries queued with nRST pulsed high between clock edges -> count=0 and empty=1 before the next edge; then push 0xBB -> instr_out=0xBB.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: the machine word, the fetch queue depth and the queue occupancy classes.
package cpu_types_pkg;
  localparam int WORD_W       = 32;
  localparam int FETCHQ_DEPTH = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_t;

  function automatic occ_t occ_decode(input int cnt, input int depth);
    if (cnt == 0)
      return OCC_EMPTY;
    else if (cnt == depth)
      return OCC_FULL;
    else
      return OCC_PARTIAL;
  endfunction
endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of the fetch_queue non-clock signals, with views for fetch, decode and a testbench.
interface fetch_queue_if;
  localparam int CW = $clog2(cpu_types_pkg::FETCHQ_DEPTH) + 1;

  logic                  nRST;
  logic                  push;
  cpu_types_pkg::word_t  instr_in;
  cpu_types_pkg::word_t  npc_in;
  logic                  pop;
  logic                  flush;
  cpu_types_pkg::word_t  instr_out;
  cpu_types_pkg::word_t  npc_out;
  logic                  valid_out;
  logic                  full;
  logic                  empty;
  logic [CW-1:0]         count;

  modport fetch (
    output push, instr_in, npc_in,
    input  full
  );

  modport decode (
    output pop, flush,
    input  instr_out, npc_out, valid_out, empty, count
  );

  modport tb (
    output nRST, push, instr_in, npc_in, pop, flush,
    input  instr_out, npc_out, valid_out, full, empty, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Fetch-to-decode FWFT instruction queue; a written entry reaches the head outputs the next cycle.
// A push is dropped when full unless a pop frees a slot that cycle; flush and reset empty it.
module fetch_queue
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = FETCHQ_DEPTH
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   push,
  input  word_t                  instr_in,
  input  word_t                  npc_in,
  input  logic                   pop,
  input  logic                   flush,
  output word_t                  instr_out,
  output word_t                  npc_out,
  output logic                   valid_out,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  word_t         r_instr_mem [DEPTH];
  word_t         r_npc_mem   [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW:0]   r_count;

  occ_t          w_occ;
  logic          w_push_acc;
  logic          w_pop_acc;

  // full/empty come only from the registered count, so push/pop never loop back into them.
  always_comb begin
    w_occ      = occ_decode(int'(r_count), DEPTH);
    empty      = (w_occ == OCC_EMPTY);
    full       = (w_occ == OCC_FULL);
    w_pop_acc  = pop && !empty;
    w_push_acc = push && (!full || w_pop_acc);
    valid_out  = !empty;
    instr_out  = empty ? '0 : r_instr_mem[r_head];
    npc_out    = empty ? '0 : r_npc_mem[r_head];
    count      = r_count;
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_acc)
        r_tail <= r_tail + PW'(1);
      if (w_pop_acc)
        r_head <= r_head + PW'(1);
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is never reset; valid_out and the zeroed head outputs hide stale slots.
  always_ff @(posedge CLK) begin
    if (w_push_acc && !flush) begin
      r_instr_mem[r_tail] <= instr_in;
      r_npc_mem[r_tail]   <= npc_in;
    end
  end
endmodule
